// File: rtl/spad_ctrl.sv
// spad_ctrl: scratchpad sequencer/arbiter for microcode, block-read and maintenance access with registered array controls
module spad_ctrl (
  input  logic       clk_h,
  input  logic       reset_l,
  input  logic       uc_req_h,
  input  logic       uc_wr_h,
  input  logic [1:0] uc_bank_h,
  input  logic [3:0] uc_addr_h,
  input  logic [1:0] uc_size_h,
  input  logic       blk_start_h,
  input  logic [1:0] blk_bank_h,
  input  logic [3:0] blk_addr_h,
  input  logic [3:0] blk_cnt_h,
  output logic       uc_busy_h,
  output logic       blk_valid_h,
  output logic       blk_last_h,
  input  logic       mnt_req_h,
  input  logic       mnt_wr_h,
  input  logic [1:0] mnt_bank_h,
  input  logic [3:0] mnt_addr_h,
  output logic       mnt_ack_h,
  output logic       wsel_mnt_h,
  output logic [3:0] rspa_h,
  output logic       rcs_tmp_l,
  output logic       rcs_gpr_l,
  output logic       rcs_ipr_l,
  output logic [3:0] spw_l
);
  typedef enum logic [2:0] {IDLE, RD, WR_SU, WR_ST, BLK, MRD, MWR_SU, MWR_ST} state_t;
  state_t st, st_n;
  logic [3:0] a_n, m, m_n, c, c_n;
  logic [1:0] b, b_n;
  logic cs, strobe;
  // Next-state values drive both the state and the registered array controls.
  always_comb begin
    st_n = st;
    a_n = rspa_h;
    b_n = b;
    m_n = m;
    c_n = c;
    case (st)
      IDLE:
        if (blk_start_h) begin
          st_n = BLK;
          a_n = blk_addr_h;
          b_n = blk_bank_h;
          c_n = blk_cnt_h;
        end else if (uc_req_h) begin
          st_n = uc_wr_h ? WR_SU : RD;
          a_n = uc_addr_h;
          b_n = uc_bank_h;
          m_n = uc_size_h == 2'b00 ? 4'b0001 : uc_size_h == 2'b01 ? 4'b0011 : 4'b1111;
        end else if (mnt_req_h) begin
          st_n = mnt_wr_h ? MWR_SU : MRD;
          a_n = mnt_addr_h;
          b_n = mnt_bank_h;
          m_n = 4'b1111;
        end
      WR_SU:  st_n = WR_ST;
      MWR_SU: st_n = MWR_ST;
      BLK:
        if (c == 4'd0) st_n = IDLE;
        else begin
          c_n = c - 4'd1;
          a_n = rspa_h + 4'd1;
        end
      default: st_n = IDLE;
    endcase
    cs = st_n != IDLE;
    strobe = st_n == WR_ST || st_n == MWR_ST;
  end
  always_ff @(posedge clk_h) begin
    if (!reset_l) begin
      st <= IDLE;
      rspa_h <= 4'd0;
      b <= 2'd0;
      m <= 4'd0;
      c <= 4'd0;
      rcs_tmp_l <= 1'b1;
      rcs_gpr_l <= 1'b1;
      rcs_ipr_l <= 1'b1;
      spw_l <= 4'hF;
      uc_busy_h <= 1'b0;
      blk_valid_h <= 1'b0;
      blk_last_h <= 1'b0;
      mnt_ack_h <= 1'b0;
      wsel_mnt_h <= 1'b0;
    end else begin
      st <= st_n;
      rspa_h <= a_n;
      b <= b_n;
      m <= m_n;
      c <= c_n;
      rcs_tmp_l <= !(cs && b_n == 2'd0);
      rcs_gpr_l <= !(cs && b_n == 2'd1);
      rcs_ipr_l <= !(cs && b_n == 2'd2);
      spw_l <= strobe ? ~m_n : 4'hF;
      uc_busy_h <= cs;
      blk_valid_h <= st_n == BLK;
      blk_last_h <= st_n == BLK && c_n == 4'd0;
      mnt_ack_h <= st_n == MRD || st_n == MWR_ST;
      wsel_mnt_h <= st_n == MWR_SU || st_n == MWR_ST;
    end
  end
endmodule

// File: tb/tb_spad_ctrl.sv
// tb_spad_ctrl: directed checks of spad_ctrl sequencing, chip selects, byte enables and arbitration
module tb_spad_ctrl;
  logic clk_h = 1'b0;
  logic reset_l = 1'b0;
  logic uc_req_h = 1'b0, uc_wr_h = 1'b0;
  logic [1:0] uc_bank_h = 2'd0, uc_size_h = 2'd0;
  logic [3:0] uc_addr_h = 4'd0;
  logic blk_start_h = 1'b0;
  logic [1:0] blk_bank_h = 2'd0;
  logic [3:0] blk_addr_h = 4'd0, blk_cnt_h = 4'd0;
  logic mnt_req_h = 1'b0, mnt_wr_h = 1'b0;
  logic [1:0] mnt_bank_h = 2'd0;
  logic [3:0] mnt_addr_h = 4'd0;
  logic uc_busy_h, blk_valid_h, blk_last_h, mnt_ack_h, wsel_mnt_h;
  logic [3:0] rspa_h, spw_l;
  logic rcs_tmp_l, rcs_gpr_l, rcs_ipr_l;
  int checks = 0;
  int errors = 0;
  spad_ctrl dut (
    .clk_h(clk_h), .reset_l(reset_l),
    .uc_req_h(uc_req_h), .uc_wr_h(uc_wr_h), .uc_bank_h(uc_bank_h), .uc_addr_h(uc_addr_h), .uc_size_h(uc_size_h),
    .blk_start_h(blk_start_h), .blk_bank_h(blk_bank_h), .blk_addr_h(blk_addr_h), .blk_cnt_h(blk_cnt_h),
    .uc_busy_h(uc_busy_h), .blk_valid_h(blk_valid_h), .blk_last_h(blk_last_h),
    .mnt_req_h(mnt_req_h), .mnt_wr_h(mnt_wr_h), .mnt_bank_h(mnt_bank_h), .mnt_addr_h(mnt_addr_h),
    .mnt_ack_h(mnt_ack_h), .wsel_mnt_h(wsel_mnt_h),
    .rspa_h(rspa_h), .rcs_tmp_l(rcs_tmp_l), .rcs_gpr_l(rcs_gpr_l), .rcs_ipr_l(rcs_ipr_l), .spw_l(spw_l)
  );
  always #5 clk_h = ~clk_h;
  // Vector layout: rspa[15:12] cs{tmp,gpr,ipr}[11:9] spw[8:5] {busy,valid,last,ack,wsel}[4:0]
  logic [15:0] obs;
  assign obs = {rspa_h, rcs_tmp_l, rcs_gpr_l, rcs_ipr_l, spw_l, uc_busy_h, blk_valid_h, blk_last_h, mnt_ack_h, wsel_mnt_h};
  task automatic tick;
    @(posedge clk_h);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    tick; tick;
    chk("reset", {4'd0, 3'b111, 4'hF, 5'b00000});
    reset_l = 1'b1;
    tick;
    chk("idle", {4'd0, 3'b111, 4'hF, 5'b00000});
    uc_req_h = 1; uc_wr_h = 0; uc_bank_h = 2'd1; uc_addr_h = 4'd5;
    tick;
    uc_req_h = 0;
    chk("rd_gpr5", {4'd5, 3'b101, 4'hF, 5'b10000});
    tick;
    chk("rd_done", {4'd5, 3'b111, 4'hF, 5'b00000});
    uc_req_h = 1; uc_wr_h = 1; uc_bank_h = 2'd0; uc_addr_h = 4'd3; uc_size_h = 2'b01;
    tick;
    uc_req_h = 0;
    chk("wr_su", {4'd3, 3'b011, 4'hF, 5'b10000});
    tick;
    chk("wr_st_word", {4'd3, 3'b011, 4'hC, 5'b10000});
    tick;
    chk("wr_done", {4'd3, 3'b111, 4'hF, 5'b00000});
    uc_req_h = 1; uc_wr_h = 0;
    tick;
    uc_req_h = 0;
    chk("reread_tmp3", {4'd3, 3'b011, 4'hF, 5'b10000});
    tick;
    uc_req_h = 1; uc_wr_h = 1; uc_bank_h = 2'd1; uc_addr_h = 4'd7; uc_size_h = 2'b00;
    tick;
    uc_req_h = 0;
    tick;
    chk("wr_st_byte", {4'd7, 3'b101, 4'hE, 5'b10000});
    tick;
    uc_req_h = 1; uc_bank_h = 2'd2; uc_addr_h = 4'd12; uc_size_h = 2'b11;
    tick;
    uc_req_h = 0;
    tick;
    chk("wr_st_long", {4'd12, 3'b110, 4'h0, 5'b10000});
    tick;
    chk("wr_long_done", {4'd12, 3'b111, 4'hF, 5'b00000});
    blk_start_h = 1; blk_bank_h = 2'd2; blk_addr_h = 4'd14; blk_cnt_h = 4'd3;
    uc_req_h = 1; uc_wr_h = 0; uc_bank_h = 2'd0; uc_addr_h = 4'd9;
    tick;
    blk_start_h = 0; uc_req_h = 0;
    chk("blk_k0", {4'd14, 3'b110, 4'hF, 5'b11000});
    tick;
    chk("blk_k1", {4'd15, 3'b110, 4'hF, 5'b11000});
    tick;
    chk("blk_k2_wrap", {4'd0, 3'b110, 4'hF, 5'b11000});
    tick;
    chk("blk_k3_last", {4'd1, 3'b110, 4'hF, 5'b11100});
    tick;
    chk("blk_done", {4'd1, 3'b111, 4'hF, 5'b00000});
    tick;
    chk("uc_dropped", {4'd1, 3'b111, 4'hF, 5'b00000});
    uc_req_h = 1; uc_wr_h = 0; uc_bank_h = 2'd0; uc_addr_h = 4'd2;
    mnt_req_h = 1; mnt_wr_h = 1; mnt_bank_h = 2'd1; mnt_addr_h = 4'd9;
    tick;
    uc_req_h = 0;
    chk("uc_wins", {4'd2, 3'b011, 4'hF, 5'b10000});
    tick;
    chk("idle_gap", {4'd2, 3'b111, 4'hF, 5'b00000});
    tick;
    mnt_addr_h = 4'd4; mnt_bank_h = 2'd0;
    chk("mwr_su", {4'd9, 3'b101, 4'hF, 5'b10001});
    tick;
    mnt_req_h = 0;
    chk("mwr_st", {4'd9, 3'b101, 4'h0, 5'b10011});
    tick;
    chk("mwr_done", {4'd9, 3'b111, 4'hF, 5'b00000});
    mnt_req_h = 1; mnt_wr_h = 0; mnt_bank_h = 2'd2; mnt_addr_h = 4'd6;
    tick;
    chk("mrd", {4'd6, 3'b110, 4'hF, 5'b10010});
    tick;
    chk("mrd_gap", {4'd6, 3'b111, 4'hF, 5'b00000});
    tick;
    mnt_req_h = 0;
    chk("mrd_again", {4'd6, 3'b110, 4'hF, 5'b10010});
    tick;
    chk("mrd_done", {4'd6, 3'b111, 4'hF, 5'b00000});
    blk_start_h = 1; blk_bank_h = 2'd0; blk_addr_h = 4'd8; blk_cnt_h = 4'd0;
    tick;
    blk_start_h = 0;
    chk("blk_cnt0", {4'd8, 3'b011, 4'hF, 5'b11100});
    tick;
    chk("blk_cnt0_done", {4'd8, 3'b111, 4'hF, 5'b00000});
    uc_req_h = 1; uc_wr_h = 0; uc_bank_h = 2'd3; uc_addr_h = 4'd10;
    tick;
    uc_req_h = 0;
    chk("rd_bank3", {4'd10, 3'b111, 4'hF, 5'b10000});
    tick;
    chk("rd_bank3_done", {4'd10, 3'b111, 4'hF, 5'b00000});
    uc_req_h = 1; uc_wr_h = 1; uc_bank_h = 2'd1; uc_addr_h = 4'd1; uc_size_h = 2'b10;
    mnt_req_h = 1; mnt_wr_h = 1;
    tick;
    uc_req_h = 0;
    tick;
    chk("wr_st_pre_reset", {4'd1, 3'b101, 4'h0, 5'b10000});
    reset_l = 0; mnt_req_h = 0;
    tick;
    chk("reset_mid_wr", {4'd0, 3'b111, 4'hF, 5'b00000});
    reset_l = 1;
    tick;
    chk("post_reset_idle", {4'd0, 3'b111, 4'hF, 5'b00000});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
